// File: rtl/uart_prog_loader.sv
// Loads a little-endian program image (16-bit word count, then the words) from a
// UART byte stream into program memory, holding the CPU in reset while loading.
module uart_prog_loader #(
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int              TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Abort fires on the idle cycle that would take the counter to TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [31:0]     MAX_WORDS = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, FLUSH, DONE, ERR
  } state_e;

  state_e                state_q;
  logic [15:0]           len_q;
  logic [ADDR_WIDTH-1:0] widx_q;
  logic [1:0]            bidx_q;
  logic [23:0]           asm_q;
  logic [TW-1:0]         tcnt_q;
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  hold_q;
  logic                  done_q;
  logic                  err_q;

  logic        waiting;
  logic [15:0] len_d;
  logic        last_word;

  assign waiting   = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
  assign len_d     = {rx_data_i, len_q[7:0]};
  assign last_word = (32'(widx_q) == (32'(len_q) - 32'd1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      len_q     <= '0;
      widx_q    <= '0;
      bidx_q    <= '0;
      asm_q     <= '0;
      tcnt_q    <= '0;
      imem_we_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;

      // Byte arrival always beats the timeout terminal count.
      if (waiting) begin
        if (rx_valid_i) begin
          tcnt_q <= '0;
        end else if (tcnt_q == TO_LAST) begin
          tcnt_q  <= '0;
          state_q <= ERR;
          err_q   <= 1'b1;
        end else begin
          tcnt_q <= tcnt_q + 1'b1;
        end
      end

      case (state_q)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            state_q <= LEN_LO;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
            widx_q  <= '0;
            bidx_q  <= '0;
            tcnt_q  <= '0;
          end
        end
        LEN_LO: begin
          if (rx_valid_i) begin
            len_q[7:0] <= rx_data_i;
            state_q    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (rx_valid_i) begin
            len_q[15:8] <= rx_data_i;
            if (len_d == 16'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else if (32'(len_d) > MAX_WORDS) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (rx_valid_i) begin
            asm_q  <= {rx_data_i, asm_q[23:8]};
            bidx_q <= bidx_q + 1'b1;
            if (bidx_q == 2'd3) begin
              imem_we_q <= 1'b1;
              addr_q    <= widx_q;
              wdata_q   <= {rx_data_i, asm_q};
              widx_q    <= widx_q + 1'b1;
              if (last_word) state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          hold_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_hold_o   = hold_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream feeder of the instruction-fetch stage: on request, loads a program image from a byte stream and writes it into the program ROM's write port.
- Byte stream comes from the UART receiver.
- Holds the CPU in reset for the whole load, so fetch restarts at PC 0 on the new image once loading finishes.

Parameters:
- ADDR_WIDTH, 14, word-address width of program memory; matches PC[15:2].
- TIMEOUT_CYCLES, 10000000, idle clocks allowed between bytes before a load aborts.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse (debounced button) requesting a load.
- rx_valid  input  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  input  8  received byte.
- imem_we  output  1  program-memory write enable, one-cycle pulse per word.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  word to write.
- cpu_hold  output  1  drives the CPU/fetch synchronous reset while loading.
- done  output  1  last load completed successfully.
- err  output  1  last load aborted.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, err=0; all counters 0.
- Stream format, all little-endian:
  - 2 bytes: word count N.
  - Then 4*N bytes.
  - Byte k of a word (k=0..3) goes to bits [8k+7:8k].
- Bytes are accepted only in LEN_LO, LEN_HI and DATA. rx_valid in any other state is ignored.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, FLUSH, DONE, ERR.
  - IDLE/DONE/ERR + start -> LEN_LO. Clear done, err, word index, byte index and timeout counter.
  - LEN_LO + byte -> LEN_HI; N[7:0] = byte.
  - LEN_HI + byte -> N[15:8] = byte. Then:
    - N==0 -> DONE.
    - N > 2^ADDR_WIDTH -> ERR.
    - Otherwise -> DATA.
  - DATA + byte -> shift byte into assembly register; byte index +1.
  - On the 4th byte:
    - Next cycle: imem_we=1, imem_addr=word index, imem_wdata=assembled word.
    - Word index +1; byte index back to 0.
    - FSM stays in DATA, so a byte arriving the very next cycle is accepted, not lost.
    - If this was word N-1, go to FLUSH instead.
  - FLUSH: carries the final imem_we pulse; unconditionally -> DONE next cycle.
  - DONE: done=1, cpu_hold=0.
  - ERR: err=1, cpu_hold=1 until the next start.
- cpu_hold is registered and equals 1 in LEN_LO, LEN_HI, DATA, FLUSH and ERR. It therefore falls the cycle after the final write.
- start while in LEN_LO/LEN_HI/DATA/FLUSH is ignored.
- Timeout:
  - Counter runs in LEN_LO, LEN_HI and DATA; it clears on every accepted byte and is held 0 elsewhere.
  - Reaching TIMEOUT_CYCLES-1 with no byte -> ERR.
  - A partially assembled word is discarded, never written.
- Simultaneous byte and timeout terminal count in the same cycle: the byte wins and the counter clears.
- imem_we is never asserted outside the cycle after a 4th byte; at most one write per clock.
- imem_addr/imem_wdata hold their last values when imem_we=0.
- Reset mid-load: immediate return to IDLE, cpu_hold=0, no further writes. Memory keeps any words already written.

Test Plan:
- Normal load:
  - Stimulus: start, then bytes 02 00 78 56 34 12 EF BE AD DE.
  - Response: imem_we pulses twice: addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF.
  - done=1, cpu_hold falls exactly 1 cycle after the second pulse.
- Zero length:
  - Stimulus: start, bytes 00 00.
  - Response: no imem_we; DONE; done=1, cpu_hold=0.
- Oversize:
  - Stimulus: start, bytes 01 40 (N=0x4001).
  - Response: err=1, cpu_hold=1, no writes. A following start plus a valid 1-word stream recovers: done=1, err=0.
- Timeout:
  - Setup: TIMEOUT_CYCLES=50.
  - Stimulus: start, 01 00, then 3 data bytes, then silence.
  - Response: err=1 after 49 idle cycles; no imem_we.
- Back-to-back bytes:
  - Stimulus: rx_valid high on every cycle for a 3-word stream.
  - Response: all 3 words written at addr 0,1,2, no byte dropped. A start pulse inserted mid-stream has no effect.
- Reset mid-load:
  - Stimulus: assert reset after word 0 is written.
  - Response: IDLE; outputs at reset values; subsequent rx bytes produce no writes.
